// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: turns a 1-bit spike train back into numbers.
// The rate path counts spikes over a programmable window and hands each
// count out through a valid/ready register; the timing path measures the
// interval between consecutive spikes.
module spike_rate_decoder #(
  parameter int CNT_W = 6,
  parameter int WIN_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             spike,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  state_t           state;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] count;

  logic [WIN_W-1:0] len_eff;
  logic [WIN_W-1:0] cur_win;
  logic [WIN_W-1:0] cur_timer;
  logic [CNT_W-1:0] cur_count;
  logic [CNT_W-1:0] result;
  logic             win_close;

  logic [ISI_W-1:0] isi_cnt;
  logic             isi_armed;

  // Window view for this cycle: the first enabled cycle out of IDLE acts as
  // window cycle 0 with a freshly latched length, so a length of 1 can close
  // on that very cycle.
  always_comb begin
    len_eff   = (window_len == '0) ? WIN_W'(1) : window_len;
    cur_win   = win;
    cur_timer = timer;
    cur_count = count;
    if (state == IDLE) begin
      cur_win   = len_eff;
      cur_timer = '0;
      cur_count = '0;
    end
    result = cur_count;
    if (spike && (cur_count != CNT_MAX)) begin
      result = cur_count + CNT_W'(1);
    end
    win_close = (cur_timer == (cur_win - WIN_W'(1)));
  end

  // Window FSM plus the rate output register and its handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      win        <= '0;
      timer      <= '0;
      count      <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ena) begin
        state <= COUNT;
        if (win_close) begin
          timer <= '0;
          count <= '0;
          win   <= len_eff;
        end else begin
          timer <= cur_timer + WIN_W'(1);
          count <= result;
          win   <= cur_win;
        end
      end
      if (ena && win_close) begin
        if (!rate_valid || rate_ready) begin
          rate_out   <= result;
          rate_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end

  // Inter-spike interval: the first spike only arms, later spikes report.
  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (ena) begin
        if (spike) begin
          if (isi_armed) begin
            isi_out   <= isi_cnt;
            isi_valid <= 1'b1;
          end
          isi_armed <= 1'b1;
          isi_cnt   <= ISI_W'(1);
        end else if (isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + ISI_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: directed stimulus, a behavioural model
// compared every cycle, and hand-computed literal checks.
module tb_spike_rate_decoder;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       spike;
  logic [7:0] window_len;
  logic [5:0] rate_out;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;
  logic [7:0] isi_out;
  logic       isi_valid;

  int total_checks = 0;
  int fail_count   = 0;

  spike_rate_decoder #(.CNT_W(6), .WIN_W(8), .ISI_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .spike      (spike),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: window progress in enabled cycles, raw spike total, and
  // an enabled-cycle timestamp of the last spike.
  bit         m_active;
  bit         m_armed;
  int         m_len;
  int         m_pos;
  int         m_spikes;
  int         en_cycle;
  int         last_spike;
  logic [5:0] exp_rate_out;
  bit         exp_rate_valid;
  bit         exp_overrun;
  logic [7:0] exp_isi_out;
  bit         exp_isi_valid;

  // Behavioural model, updated on each rising edge from the sampled inputs.
  always @(posedge clk) begin : model
    bit close;
    int isi;
    close = 1'b0;
    if (reset) begin
      m_active       = 1'b0;
      m_armed        = 1'b0;
      m_len          = 1;
      m_pos          = 0;
      m_spikes       = 0;
      en_cycle       = 0;
      last_spike     = 0;
      exp_rate_out   = '0;
      exp_rate_valid = 1'b0;
      exp_overrun    = 1'b0;
      exp_isi_out    = '0;
      exp_isi_valid  = 1'b0;
    end else begin
      exp_isi_valid = 1'b0;
      if (ena) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_len    = (window_len == 0) ? 1 : int'(window_len);
          m_pos    = 0;
          m_spikes = 0;
        end
        m_spikes = m_spikes + int'(spike);
        m_pos    = m_pos + 1;
        close    = (m_pos == m_len);
        en_cycle = en_cycle + 1;
        if (spike) begin
          if (m_armed) begin
            isi           = en_cycle - last_spike;
            exp_isi_out   = 8'((isi > 255) ? 255 : isi);
            exp_isi_valid = 1'b1;
          end
          m_armed    = 1'b1;
          last_spike = en_cycle;
        end
      end
      if (close) begin
        if (!exp_rate_valid || rate_ready) begin
          exp_rate_out   = 6'((m_spikes > 63) ? 63 : m_spikes);
          exp_rate_valid = 1'b1;
        end else begin
          exp_overrun = 1'b1;
        end
        m_pos    = 0;
        m_spikes = 0;
        m_len    = (window_len == 0) ? 1 : int'(window_len);
      end else if (exp_rate_valid && rate_ready) begin
        exp_rate_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model just after each rising edge.
  always @(posedge clk) begin
    #1;
    checkOutput("model rate_out", int'(rate_out), int'(exp_rate_out));
    checkOutput("model rate_valid", int'(rate_valid), int'(exp_rate_valid));
    checkOutput("model overrun", int'(overrun), int'(exp_overrun));
    checkOutput("model isi_out", int'(isi_out), int'(exp_isi_out));
    checkOutput("model isi_valid", int'(isi_valid), int'(exp_isi_valid));
  end

  task automatic applyStimulus(input logic en, input logic sp, input logic [7:0] len,
                               input logic rdy);
    ena        = en;
    spike      = sp;
    window_len = len;
    rate_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    tick(1);
    reset = 1'b0;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    tick(2);
    checkOutput("reset rate_out", int'(rate_out), 0);
    checkOutput("reset rate_valid", int'(rate_valid), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset isi_out", int'(isi_out), 0);
    checkOutput("reset isi_valid", int'(isi_valid), 0);
    reset = 1'b0;

    $display("[TB] full-rate window of 8, then window_len 0");
    applyStimulus(1'b1, 1'b1, 8'd8, 1'b1);
    tick(7);
    checkOutput("w8 not yet valid", int'(rate_valid), 0);
    tick(1);
    checkOutput("w8 valid", int'(rate_valid), 1);
    checkOutput("w8 rate_out", int'(rate_out), 8);
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b1);
    tick(1);
    checkOutput("w8 consumed", int'(rate_valid), 0);
    checkOutput("back-to-back isi", int'(isi_out), 1);
    tick(11);
    checkOutput("w0 rate_out", int'(rate_out), 1);
    checkOutput("w0 valid", int'(rate_valid), 1);

    $display("[TB] saturation over a window of 100");
    doReset();
    applyStimulus(1'b1, 1'b1, 8'd100, 1'b1);
    tick(99);
    checkOutput("w100 not yet valid", int'(rate_valid), 0);
    tick(1);
    checkOutput("w100 saturated", int'(rate_out), 63);
    checkOutput("w100 valid", int'(rate_valid), 1);

    $display("[TB] backpressure and overrun");
    doReset();
    applyStimulus(1'b1, 1'b1, 8'd4, 1'b0);
    tick(4);
    checkOutput("bp first count", int'(rate_out), 4);
    checkOutput("bp no overrun yet", int'(overrun), 0);
    tick(4);
    checkOutput("bp held count", int'(rate_out), 4);
    checkOutput("bp still valid", int'(rate_valid), 1);
    checkOutput("bp overrun", int'(overrun), 1);
    applyStimulus(1'b1, 1'b1, 8'd4, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 8'd4, 1'b0);
    checkOutput("bp drained", int'(rate_valid), 0);
    checkOutput("bp overrun sticky", int'(overrun), 1);
    tick(3);

    $display("[TB] inter-spike intervals");
    doReset();
    applyStimulus(1'b1, 1'b0, 8'd200, 1'b1);
    for (int k = 0; k <= 23; k++) begin
      spike = (k == 10 || k == 13 || k == 23);
      tick(1);
      if (k == 10) checkOutput("isi first spike arms only", int'(isi_valid), 0);
      if (k == 13) begin
        checkOutput("isi pulse 3", int'(isi_valid), 1);
        checkOutput("isi value 3", int'(isi_out), 3);
      end
      if (k == 23) begin
        checkOutput("isi pulse 10", int'(isi_valid), 1);
        checkOutput("isi value 10", int'(isi_out), 10);
      end
    end
    spike = 1'b0;
    tick(300);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;
    checkOutput("isi long gap pulse", int'(isi_valid), 1);
    checkOutput("isi saturated", int'(isi_out), 255);

    $display("[TB] enable gap stretches the window");
    doReset();
    applyStimulus(1'b1, 1'b1, 8'd8, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b1, 8'd8, 1'b1);
    tick(5);
    checkOutput("gap no early close", int'(rate_valid), 0);
    applyStimulus(1'b1, 1'b1, 8'd8, 1'b1);
    tick(4);
    checkOutput("gap not yet valid", int'(rate_valid), 0);
    tick(1);
    checkOutput("gap valid", int'(rate_valid), 1);
    checkOutput("gap count excludes frozen", int'(rate_out), 8);

    $display("[TB] reset mid-window");
    doReset();
    applyStimulus(1'b1, 1'b1, 8'd4, 1'b0);
    tick(6);
    checkOutput("pre-reset valid", int'(rate_valid), 1);
    reset = 1'b1;
    tick(1);
    checkOutput("mid reset rate_out", int'(rate_out), 0);
    checkOutput("mid reset rate_valid", int'(rate_valid), 0);
    checkOutput("mid reset overrun", int'(overrun), 0);
    checkOutput("mid reset isi_out", int'(isi_out), 0);
    checkOutput("mid reset isi_valid", int'(isi_valid), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd4, 1'b1);
    tick(3);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;
    checkOutput("post-reset spike arms only", int'(isi_valid), 0);
    tick(2);
    spike = 1'b1;
    tick(1);
    spike = 1'b0;
    checkOutput("post-reset isi pulse", int'(isi_valid), 1);
    checkOutput("post-reset isi value", int'(isi_out), 3);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
